sdram_arbiter_rr: RTL and testbench

SDRAM_ARBITER_RR -- requirements
Module: sdram_arbiter_rr

---
 rtl/sdram_arbiter_rr.sv | 247 ++++++++++++++++++++++++
 tb/tb_sdram_arbiter_rr.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter_rr.sv
// sdram_arbiter_rr -- shares one SDRAM controller between NUM_CH requesters.
//
// Each channel owns one pending slot. A single-cycle strobe is captured into the
// slot when the channel is not busy. A four-state FSM picks one pending slot
// (round-robin or fixed priority), issues it to the controller for one cycle,
// then waits for write completion (ctrl_busy low) or read data (ctrl_out_valid).
//
// Parameters
//   NUM_CH  number of requester channels (2..8)
//   ADDR_W  SDRAM word address width
//   DATA_W  data width
//   MODE    0 = round-robin, 1 = fixed priority (channel 0 highest)
//
// Ports
//   wb_clk_i / wb_rst_i       clock, synchronous active-high reset
//   req_address/rw/wdata/     per-channel request fields, channel i at slice i
//   req_in_valid/prefetch_step
//   req_busy                  channel cannot take a strobe this cycle
//   req_out_valid             read data valid for that channel (one cycle)
//   req_rdata                 read data, broadcast straight from ctrl_rdata
//   ctrl_*                    single request port toward the SDRAM controller

// One pending request slot. Captures a strobe when not busy, drops the pending
// flag when the arbiter retires the transaction it belongs to.
module sdram_arbiter_rr_slot #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stb,
  input  logic              i_busy,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_rw,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pf,
  output logic              o_pend,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_rw,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_pf
);
  logic              r_pend;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rw;
  logic [DATA_W-1:0] r_wdata;
  logic              r_pf;

  // Accept and retire never coincide: a channel being retired is the owner and
  // therefore busy, so its strobe is dropped on that edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend  <= 1'b0;
      r_addr  <= '0;
      r_rw    <= 1'b0;
      r_wdata <= '0;
      r_pf    <= 1'b0;
    end else if (i_stb && !i_busy) begin
      r_pend  <= 1'b1;
      r_addr  <= i_addr;
      r_rw    <= i_rw;
      r_wdata <= i_wdata;
      r_pf    <= i_pf;
    end else if (i_clr) begin
      r_pend  <= 1'b0;
    end
  end

  assign o_pend  = r_pend;
  assign o_addr  = r_addr;
  assign o_rw    = r_rw;
  assign o_wdata = r_wdata;
  assign o_pf    = r_pf;
endmodule

module sdram_arbiter_rr #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32,
  parameter int MODE   = 0
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [NUM_CH*ADDR_W-1:0] req_address,
  input  logic [NUM_CH-1:0]        req_rw,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  input  logic [NUM_CH-1:0]        req_in_valid,
  input  logic [NUM_CH-1:0]        req_prefetch_step,
  output logic [NUM_CH-1:0]        req_busy,
  output logic [NUM_CH-1:0]        req_out_valid,
  output logic [DATA_W-1:0]        req_rdata,
  output logic [ADDR_W-1:0]        ctrl_address,
  output logic                     ctrl_rw,
  output logic [DATA_W-1:0]        ctrl_wdata,
  output logic                     ctrl_in_valid,
  output logic                     ctrl_prefetch_step,
  input  logic                     ctrl_busy,
  input  logic [DATA_W-1:0]        ctrl_rdata,
  input  logic                     ctrl_out_valid
);
  localparam int OW = $clog2(NUM_CH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_WR = 2'd2,
    S_WAIT_RD = 2'd3
  } state_t;

  state_t                          r_state, w_state_nx;
  logic   [OW-1:0]                 r_owner;
  logic   [OW-1:0]                 r_last;

  logic   [NUM_CH-1:0]             w_pend;
  logic   [NUM_CH-1:0]             w_busy;
  logic   [NUM_CH-1:0]             w_clr;
  logic   [NUM_CH-1:0][ADDR_W-1:0] w_slot_addr;
  logic   [NUM_CH-1:0]             w_slot_rw;
  logic   [NUM_CH-1:0][DATA_W-1:0] w_slot_wdata;
  logic   [NUM_CH-1:0]             w_slot_pf;

  logic                            w_active;
  logic                            w_drive;
  logic   [OW-1:0]                 w_grant;
  logic                            w_gnt_vld;
  logic                            w_take;
  logic                            w_done;
  logic                            w_rd_ok;

  // The owner stays busy for the whole transaction even though its pending bit
  // is also set; this keeps busy correct if the two ever diverge.
  assign w_active = (r_state != S_IDLE);
  // Reset gates every outward signal immediately, not only after the edge.
  assign w_drive  = w_active && !wb_rst_i;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_busy[g]        = w_pend[g] | (w_active & (r_owner == OW'(g)));
    assign w_clr[g]         = w_done & (r_owner == OW'(g));
    assign req_busy[g]      = w_busy[g] & ~wb_rst_i;
    assign req_out_valid[g] = w_rd_ok & (r_owner == OW'(g)) & ~wb_rst_i;

    sdram_arbiter_rr_slot #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_slot (
      .i_clk   (wb_clk_i),
      .i_rst   (wb_rst_i),
      .i_stb   (req_in_valid[g]),
      .i_busy  (w_busy[g]),
      .i_clr   (w_clr[g]),
      .i_addr  (req_address[g*ADDR_W +: ADDR_W]),
      .i_rw    (req_rw[g]),
      .i_wdata (req_wdata[g*DATA_W +: DATA_W]),
      .i_pf    (req_prefetch_step[g]),
      .o_pend  (w_pend[g]),
      .o_addr  (w_slot_addr[g]),
      .o_rw    (w_slot_rw[g]),
      .o_wdata (w_slot_wdata[g]),
      .o_pf    (w_slot_pf[g])
    );
  end

  // Grant select. Loops run from the lowest-priority candidate to the highest so
  // the last hit written is the winner.
  always_comb begin
    logic [OW:0] v_idx;
    w_gnt_vld = 1'b0;
    w_grant   = '0;
    v_idx     = '0;
    if (MODE == 1) begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (w_pend[k]) begin
          w_gnt_vld = 1'b1;
          w_grant   = OW'(k);
        end
      end
    end else begin
      // Candidates are last_grant+1 .. last_grant+NUM_CH, wrapped modulo NUM_CH.
      for (int k = NUM_CH; k >= 1; k--) begin
        v_idx = {1'b0, r_last} + (OW+1)'(k);
        if (v_idx >= (OW+1)'(NUM_CH)) v_idx = v_idx - (OW+1)'(NUM_CH);
        if (w_pend[v_idx[OW-1:0]]) begin
          w_gnt_vld = 1'b1;
          w_grant   = v_idx[OW-1:0];
        end
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_take     = 1'b0;
    w_done     = 1'b0;
    w_rd_ok    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_vld && !ctrl_busy) begin
          w_take     = 1'b1;
          w_state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nx = w_slot_rw[r_owner] ? S_WAIT_WR : S_WAIT_RD;
      end
      S_WAIT_WR: begin
        if (!ctrl_busy) begin
          w_done     = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      S_WAIT_RD: begin
        if (ctrl_out_valid) begin
          w_done     = 1'b1;
          w_rd_ok    = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // last_grant starts at NUM_CH-1 so the first round-robin search begins at ch0.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_last  <= OW'(NUM_CH - 1);
    end else begin
      r_state <= w_state_nx;
      if (w_take) begin
        r_owner <= w_grant;
        if (MODE == 0) r_last <= w_grant;
      end
    end
  end

  // Controller fields come straight from the owner's slot, which cannot change
  // while the owner is busy, so they hold from ISSUE until back in IDLE.
  assign ctrl_in_valid      = (r_state == S_ISSUE) && !wb_rst_i;
  assign ctrl_address       = w_drive ? w_slot_addr[r_owner]  : '0;
  assign ctrl_rw            = w_drive ? w_slot_rw[r_owner]    : 1'b0;
  assign ctrl_wdata         = w_drive ? w_slot_wdata[r_owner] : '0;
  assign ctrl_prefetch_step = w_drive ? w_slot_pf[r_owner]    : 1'b0;

  assign req_rdata = ctrl_rdata;
endmodule

// File: tb/tb_sdram_arbiter_rr.sv
// Bench for sdram_arbiter_rr: one round-robin and one fixed-priority instance
// share stimulus; sel picks which one the scoreboard and controller follow.
module tb_sdram_arbiter_rr;
  localparam int NC = 3;
  localparam int AW = 24;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NC*AW-1:0] req_address;
  logic [NC-1:0]    req_rw;
  logic [NC*DW-1:0] req_wdata;
  logic [NC-1:0]    req_in_valid;
  logic [NC-1:0]    req_prefetch_step;
  logic             ctrl_busy;
  logic [DW-1:0]    ctrl_rdata;
  logic             ctrl_out_valid;
  logic             sel;

  logic [NC-1:0] rr_busy, rr_ov, fp_busy, fp_ov;
  logic [DW-1:0] rr_rd, fp_rd, rr_cwd, fp_cwd;
  logic [AW-1:0] rr_ca, fp_ca;
  logic          rr_crw, fp_crw, rr_civ, fp_civ, rr_cpf, fp_cpf;

  sdram_arbiter_rr #(.NUM_CH(NC), .ADDR_W(AW), .DATA_W(DW), .MODE(0)) u_rr (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_address(req_address), .req_rw(req_rw), .req_wdata(req_wdata),
    .req_in_valid(req_in_valid), .req_prefetch_step(req_prefetch_step),
    .req_busy(rr_busy), .req_out_valid(rr_ov), .req_rdata(rr_rd),
    .ctrl_address(rr_ca), .ctrl_rw(rr_crw), .ctrl_wdata(rr_cwd),
    .ctrl_in_valid(rr_civ), .ctrl_prefetch_step(rr_cpf),
    .ctrl_busy(ctrl_busy), .ctrl_rdata(ctrl_rdata), .ctrl_out_valid(ctrl_out_valid));

  sdram_arbiter_rr #(.NUM_CH(NC), .ADDR_W(AW), .DATA_W(DW), .MODE(1)) u_fp (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_address(req_address), .req_rw(req_rw), .req_wdata(req_wdata),
    .req_in_valid(req_in_valid), .req_prefetch_step(req_prefetch_step),
    .req_busy(fp_busy), .req_out_valid(fp_ov), .req_rdata(fp_rd),
    .ctrl_address(fp_ca), .ctrl_rw(fp_crw), .ctrl_wdata(fp_cwd),
    .ctrl_in_valid(fp_civ), .ctrl_prefetch_step(fp_cpf),
    .ctrl_busy(ctrl_busy), .ctrl_rdata(ctrl_rdata), .ctrl_out_valid(ctrl_out_valid));

  logic [NC-1:0] s_busy, s_ov;
  logic [DW-1:0] s_rd, s_cwd;
  logic [AW-1:0] s_ca;
  logic          s_crw, s_civ, s_cpf;
  assign s_busy = sel ? fp_busy : rr_busy;
  assign s_ov   = sel ? fp_ov   : rr_ov;
  assign s_rd   = sel ? fp_rd   : rr_rd;
  assign s_cwd  = sel ? fp_cwd  : rr_cwd;
  assign s_ca   = sel ? fp_ca   : rr_ca;
  assign s_crw  = sel ? fp_crw  : rr_crw;
  assign s_civ  = sel ? fp_civ  : rr_civ;
  assign s_cpf  = sel ? fp_cpf  : rr_cpf;

  typedef struct { logic [AW-1:0] a; logic rw; logic [DW-1:0] d; logic pf; } iss_t;
  typedef struct { logic [NC-1:0] m; logic [DW-1:0] d; } rd_t;
  iss_t q_iss[$];
  rd_t  q_rd[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard: every issue and every read return is matched against the queues.
  initial begin : monitor
    iss_t e;
    rd_t  r;
    forever begin
      @(negedge clk);
      #2;
      if (s_civ) begin
        if (q_iss.size() == 0) chk("unexp_issue", 64'd1, 64'd0);
        else begin
          e = q_iss.pop_front();
          chk("iss_addr",  64'(s_ca),  64'(e.a));
          chk("iss_rw",    64'(s_crw), 64'(e.rw));
          chk("iss_wdata", 64'(s_cwd), 64'(e.d));
          chk("iss_pf",    64'(s_cpf), 64'(e.pf));
        end
      end
      if (s_ov != '0) begin
        if (q_rd.size() == 0) chk("unexp_rdv", 64'(s_ov), 64'd0);
        else begin
          r = q_rd.pop_front();
          chk("rd_mask", 64'(s_ov), 64'(r.m));
          chk("rd_data", 64'(s_rd), 64'(r.d));
        end
      end
    end
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic set_req(input int ch, input logic [AW-1:0] a, input logic rw,
                         input logic [DW-1:0] d, input logic pf);
    req_address[ch*AW +: AW] = a;
    req_rw[ch]               = rw;
    req_wdata[ch*DW +: DW]   = d;
    req_prefetch_step[ch]    = pf;
    req_in_valid[ch]         = 1'b1;
  endtask

  task automatic exp_iss(input logic [AW-1:0] a, input logic rw, input logic [DW-1:0] d,
                         input logic pf);
    iss_t e;
    e.a = a; e.rw = rw; e.d = d; e.pf = pf;
    q_iss.push_back(e);
  endtask

  task automatic exp_rd(input logic [NC-1:0] m, input logic [DW-1:0] d);
    rd_t r;
    r.m = m; r.d = d;
    q_rd.push_back(r);
  endtask

  task automatic strobe_end();
    @(negedge clk);
    req_in_valid = '0;
  endtask

  task automatic wait_issue(input string tag);
    int n = 0;
    while (!s_civ && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_civ) chk(tag, 64'd0, 64'd1);
  endtask

  // Controller model: called at the negedge of an ISSUE cycle. Busy for lat
  // cycles, then completes a write or returns read data for one cycle.
  task automatic serve(input int lat, input logic [DW-1:0] rd);
    logic rw;
    rw = s_crw;
    ctrl_busy = 1'b1;
    repeat (lat) @(negedge clk);
    ctrl_busy = 1'b0;
    if (!rw) begin
      ctrl_out_valid = 1'b1;
      ctrl_rdata     = rd;
    end
    @(negedge clk);
    ctrl_out_valid = 1'b0;
  endtask

  initial begin : main
    rst = 1'b1; sel = 1'b0;
    req_address = '0; req_rw = '0; req_wdata = '0; req_in_valid = '0; req_prefetch_step = '0;
    ctrl_busy = 1'b0; ctrl_rdata = '0; ctrl_out_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 64'(s_busy), 64'd0);
    chk("rst_ov",   64'(s_ov),   64'd0);
    chk("rst_ctrl", 64'({s_civ, s_crw, s_cpf, s_ca}), 64'd0);
    chk("rst_cwd",  64'(s_cwd),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single write on ch1: two-cycle latency, busy until ctrl_busy falls.
    exp_iss(24'h000010, 1'b1, 32'hDEADBEEF, 1'b0);
    set_req(1, 24'h000010, 1'b1, 32'hDEADBEEF, 1'b0);
    strobe_end();
    chk("wr_busy_acc", 64'(s_busy), 64'h2);
    chk("wr_lat1",     64'(s_civ),  64'd0);
    @(negedge clk);
    chk("wr_lat2",     64'(s_civ),  64'd1);
    ctrl_busy = 1'b1;
    repeat (3) @(negedge clk);
    chk("wr_hold_busy", 64'(s_busy), 64'h2);
    chk("wr_hold_addr", 64'(s_ca),   64'h10);
    chk("wr_one_shot",  64'(s_civ),  64'd0);
    ctrl_busy = 1'b0;
    @(negedge clk);
    chk("wr_busy_clr",  64'(s_busy), 64'd0);
    chk("idle_addr",    64'({s_ca, s_cwd}), 64'd0);

    // Single read on ch2.
    exp_iss(24'h000020, 1'b0, 32'h0, 1'b0);
    exp_rd(3'b100, 32'h12345678);
    set_req(2, 24'h000020, 1'b0, 32'h0, 1'b0);
    strobe_end();
    wait_issue("rd_issue_to");
    serve(3, 32'h12345678);
    chk("rd_busy_clr", 64'(s_busy), 64'd0);

    // ctrl_out_valid while idle is ignored; rdata is always broadcast.
    ctrl_out_valid = 1'b1;
    ctrl_rdata     = 32'hA5A55A5A;
    #1;
    chk("ov_idle",     64'(s_ov), 64'd0);
    chk("rdata_bcast", 64'(s_rd), 64'hA5A55A5A);
    @(negedge clk);
    ctrl_out_valid = 1'b0;

    // Round-robin: simultaneous strobes serve ch0, ch1, ch2.
    exp_iss(24'h000100, 1'b1, 32'h00000A00, 1'b1);
    exp_iss(24'h000101, 1'b0, 32'h0,        1'b0);
    exp_iss(24'h000102, 1'b1, 32'h00000C00, 1'b0);
    exp_rd(3'b010, 32'h11110001);
    set_req(0, 24'h000100, 1'b1, 32'h00000A00, 1'b1);
    set_req(1, 24'h000101, 1'b0, 32'h0,        1'b0);
    set_req(2, 24'h000102, 1'b1, 32'h00000C00, 1'b0);
    strobe_end();
    chk("rr_busy_all", 64'(s_busy), 64'h7);
    wait_issue("rr_issue0_to");
    serve(2, 32'h0);
    wait_issue("rr_issue1_to");
    serve(2, 32'h11110001);
    wait_issue("rr_issue2_to");
    // During ch2 service: ch0 is accepted, ch2's strobe must be dropped.
    set_req(0, 24'h000200, 1'b1, 32'h00000A01, 1'b0);
    set_req(2, 24'h0002FF, 1'b1, 32'hBAD0BAD0, 1'b1);
    ctrl_busy = 1'b1;
    strobe_end();
    chk("rr_busy_svc", 64'(s_busy), 64'h5);
    @(negedge clk);
    ctrl_busy = 1'b0;
    @(negedge clk);
    chk("rr_ch2_free", 64'(s_busy), 64'h1);
    exp_iss(24'h000200, 1'b1, 32'h00000A01, 1'b0);
    exp_iss(24'h000202, 1'b1, 32'h00000C01, 1'b1);
    set_req(2, 24'h000202, 1'b1, 32'h00000C01, 1'b1);
    strobe_end();
    wait_issue("rr_issue3_to");
    serve(1, 32'h0);
    wait_issue("rr_issue4_to");
    serve(1, 32'h0);

    // ctrl_busy hold-off: nothing issues while the controller is busy.
    ctrl_busy = 1'b1;
    exp_iss(24'h000300, 1'b1, 32'h00000300, 1'b0);
    set_req(0, 24'h000300, 1'b1, 32'h00000300, 1'b0);
    strobe_end();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("holdoff", 64'(s_civ), 64'd0);
    end
    ctrl_busy = 1'b0;
    @(negedge clk);
    chk("holdoff_rel", 64'(s_civ), 64'd1);
    serve(1, 32'h0);

    // Reset in the middle of a read: the late data must not be forwarded.
    exp_iss(24'h000400, 1'b0, 32'h0, 1'b0);
    set_req(1, 24'h000400, 1'b0, 32'h0, 1'b0);
    strobe_end();
    wait_issue("rst_rd_issue_to");
    ctrl_busy = 1'b1;
    @(negedge clk);
    chk("rdwait_busy", 64'(s_busy), 64'h2);
    rst = 1'b1;
    #1;
    chk("rst_during", 64'({s_busy, s_civ, s_ca}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ctrl_busy      = 1'b0;
    ctrl_out_valid = 1'b1;
    ctrl_rdata     = 32'hFEEDF00D;
    #1;
    chk("rst_ov",    64'(s_ov),   64'd0);
    chk("rst_busy2", 64'(s_busy), 64'd0);
    @(negedge clk);
    ctrl_out_valid = 1'b0;
    chk("rr_q_empty", 64'(q_iss.size() + q_rd.size()), 64'd0);

    // Fixed priority: ch0 keeps winning while ch2 waits.
    sel = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_iss(24'h000500, 1'b1, 32'h00000500, 1'b0);
    set_req(0, 24'h000500, 1'b1, 32'h00000500, 1'b0);
    set_req(2, 24'h0005F2, 1'b1, 32'h000005F2, 1'b1);
    strobe_end();
    for (int r = 0; r < 3; r++) begin
      wait_issue("fp_issue_to");
      serve(1, 32'h0);
      chk("fp_ch2_wait", 64'(s_busy[2]), 64'd1);
      if (r < 2) begin
        // Controller stays busy one idle cycle so ch0's re-strobe lands first.
        exp_iss(24'(32'h510 + r), 1'b1, 32'h510 + 32'(r), 1'b0);
        set_req(0, 24'(32'h510 + r), 1'b1, 32'h510 + 32'(r), 1'b0);
        ctrl_busy = 1'b1;
        strobe_end();
        ctrl_busy = 1'b0;
      end
    end
    exp_iss(24'h0005F2, 1'b1, 32'h000005F2, 1'b1);
    wait_issue("fp_issue_ch2_to");
    serve(1, 32'h0);

    repeat (3) @(negedge clk);
    chk("q_iss_empty", 64'(q_iss.size()), 64'd0);
    chk("q_rd_empty",  64'(q_rd.size()),  64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
